cpu_mem_responder: RTL and testbench



---
 rtl/cpu_mem_pkg.sv | 20 ++
 rtl/cpu_mem_ram16x8.sv | 38 +++
 rtl/cpu_mem_responder.sv | 170 +++++++++++++++++
 tb/tb_cpu_mem_responder.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg
// Shared definitions for the CPU memory responder slice.
// Contents:
//   CPU_MEM_AW / CPU_MEM_DW   default address and data widths of the CPU bus
//   CPU_MEM_PROT_LIMIT        default first CPU-writable address, only used when
//                             CPU_MEM_WR_PROTECT_EN is defined
//   cpu_mem_state_t           responder state encoding (IDLE / LOAD / RUN)
package cpu_mem_pkg;

    localparam int CPU_MEM_AW         = 4;
    localparam int CPU_MEM_DW         = 8;
    localparam int CPU_MEM_PROT_LIMIT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } cpu_mem_state_t;

endpackage

// File: rtl/cpu_mem_ram16x8.sv
// cpu_mem_ram16x8
// Small RAM with one synchronous write port and one combinational read port.
// Contents are never cleared, so a reset elsewhere leaves loaded data intact.
// Ports:
//   clk    system clock
//   we     write enable, sampled on the rising edge
//   waddr  write address
//   wdata  write data
//   raddr  read address
//   rdata  read data, follows raddr with no clock latency
import cpu_mem_pkg::*;

module cpu_mem_ram16x8 #(
    parameter int AW = CPU_MEM_AW,
    parameter int DW = CPU_MEM_DW
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    // Single write port; whoever owns the bus this cycle is chosen by the top.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // The CPU samples read data one edge after driving the address,
    // so the read path has to be purely combinational.
    assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder
// Memory-side responder for the CPU bus: a 16x8 RAM plus a byte-stream program
// loader that fills RAM from address 0 while holding the CPU in reset.
// Optional build macro: CPU_MEM_WR_PROTECT_EN drops CPU writes below PROT_LIMIT
// and flags them on a sticky prot_err.
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   mem_address         CPU address
//   mem_data_w, mem_we  CPU write data / write enable (only honoured in RUN)
//   mem_data_r          read data for mem_address, combinational
//   cpu_reset_n         registered active-low reset to the CPU
//   ld_start            pulse: begin (or restart) a program load
//   run_start           pulse: release the CPU without loading
//   ld_valid, ld_data,
//   ld_last, ld_ready   loader byte stream handshake
//   ld_count            bytes accepted in the current/last load
//   wr_count            CPU writes performed, saturating at 255
//   prot_err            sticky write-protect violation flag
import cpu_mem_pkg::*;

module cpu_mem_responder #(
    parameter int AW = CPU_MEM_AW,
    parameter int DW = CPU_MEM_DW
`ifdef CPU_MEM_WR_PROTECT_EN
    , parameter int PROT_LIMIT = CPU_MEM_PROT_LIMIT
`endif
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] mem_address,
    input  logic [DW-1:0] mem_data_w,
    input  logic          mem_we,
    output logic [DW-1:0] mem_data_r,
    output logic          cpu_reset_n,
    input  logic          ld_start,
    input  logic          run_start,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    output logic [AW:0]   ld_count,
    output logic [7:0]    wr_count,
    output logic          prot_err
);

    localparam logic [AW:0] LD_MAX = {1'b1, {AW{1'b0}}};

    cpu_mem_state_t state, next_state;
    logic [AW-1:0]  ptr;
    logic           ld_restart;
    logic           ld_write;
    logic           cpu_write;
    logic           cpu_wr_ok;
    logic           ram_we;
    logic [AW-1:0]  ram_waddr;
    logic [DW-1:0]  ram_wdata;

`ifdef CPU_MEM_WR_PROTECT_EN
    assign cpu_wr_ok = (int'(mem_address) >= PROT_LIMIT);
`else
    assign cpu_wr_ok = 1'b1;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and strobes. A byte offered alongside ld_start in LOAD is
    // dropped because the restart wins. Reaching the last RAM location ends
    // the load even without ld_last, so ld_ready is low before any overflow.
    always_comb begin
        next_state = state;
        ld_ready   = 1'b0;
        ld_restart = 1'b0;
        ld_write   = 1'b0;
        cpu_write  = 1'b0;
        unique case (state)
            IDLE: begin
                if (ld_start) begin
                    next_state = LOAD;
                    ld_restart = 1'b1;
                end else if (run_start) begin
                    next_state = RUN;
                end
            end
            LOAD: begin
                ld_ready = 1'b1;
                if (ld_start) begin
                    ld_restart = 1'b1;
                end else if (ld_valid) begin
                    ld_write = 1'b1;
                    if (ld_last || (ptr == '1)) begin
                        next_state = RUN;
                    end
                end
            end
            RUN: begin
                cpu_write = mem_we && cpu_wr_ok;
                if (ld_start) begin
                    next_state = LOAD;
                    ld_restart = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Loader and CPU never own the write port in the same state.
    always_comb begin
        ram_we    = ld_write || cpu_write;
        ram_waddr = ld_write ? ptr     : mem_address;
        ram_wdata = ld_write ? ld_data : mem_data_w;
    end

    // Datapath registers. cpu_reset_n rises one edge after RUN is entered,
    // but drops on the very edge that leaves RUN so the CPU never runs
    // while the loader owns memory.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr         <= '0;
            ld_count    <= '0;
            wr_count    <= '0;
            prot_err    <= 1'b0;
            cpu_reset_n <= 1'b0;
        end else begin
            cpu_reset_n <= (state == RUN) && (next_state == RUN);
            if (ld_restart) begin
                ptr      <= '0;
                ld_count <= '0;
            end else if (ld_write) begin
                ptr <= ptr + 1'b1;
                if (ld_count != LD_MAX) begin
                    ld_count <= ld_count + 1'b1;
                end
            end
            if (cpu_write && (wr_count != 8'hFF)) begin
                wr_count <= wr_count + 8'd1;
            end
`ifdef CPU_MEM_WR_PROTECT_EN
            if ((state == RUN) && mem_we && !cpu_wr_ok) begin
                prot_err <= 1'b1;
            end else if (ld_start) begin
                prot_err <= 1'b0;
            end
`else
            prot_err <= 1'b0;
`endif
        end
    end

    cpu_mem_ram16x8 #(
        .AW(AW),
        .DW(DW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (mem_address),
        .rdata (mem_data_r)
    );

endmodule

// File: tb/tb_cpu_mem_responder.sv
// tb_cpu_mem_responder
// Directed bench for cpu_mem_responder with hand-computed expected values.
// Inputs change on the falling edge and outputs are sampled there too.
`timescale 1ns/1ps
module tb_cpu_mem_responder;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] mem_address;
    logic [7:0] mem_data_w;
    logic       mem_we;
    logic [7:0] mem_data_r;
    logic       cpu_reset_n;
    logic       ld_start;
    logic       run_start;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic       ld_last;
    logic       ld_ready;
    logic [4:0] ld_count;
    logic [7:0] wr_count;
    logic       prot_err;

    int checks = 0;
    int errors = 0;

    cpu_mem_responder dut (
        .clk         (clk),
        .reset       (reset),
        .mem_address (mem_address),
        .mem_data_w  (mem_data_w),
        .mem_we      (mem_we),
        .mem_data_r  (mem_data_r),
        .cpu_reset_n (cpu_reset_n),
        .ld_start    (ld_start),
        .run_start   (run_start),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .ld_ready    (ld_ready),
        .ld_count    (ld_count),
        .wr_count    (wr_count),
        .prot_err    (prot_err)
    );

    // Free-running clock, 10 ns period.
    always #5 clk = ~clk;

    // Single comparison point for every check in the bench.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Let one rising edge consume the current inputs, then return at the falling edge.
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Read through the combinational port between clock edges.
    task automatic checkRam(input string tag, input logic [3:0] addr, input logic [7:0] exp);
        mem_address = addr;
        #1;
        checkOutput(tag, {24'd0, mem_data_r}, {24'd0, exp});
    endtask

    initial begin
        logic saw_ready_drop;
        reset = 1'b1; mem_address = '0; mem_data_w = '0; mem_we = 1'b0;
        ld_start = 1'b0; run_start = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
        @(negedge clk);
        applyStimulus(2);
        reset = 1'b0;
        #1;
        checkOutput("rst_cpu_reset_n", cpu_reset_n, 0);
        checkOutput("rst_ld_ready", ld_ready, 0);
        checkOutput("rst_ld_count", ld_count, 0);
        checkOutput("rst_wr_count", wr_count, 0);
        checkOutput("rst_prot_err", prot_err, 0);
        @(negedge clk);

        // Three-byte load terminated by ld_last.
        ld_start = 1'b1; applyStimulus(1); ld_start = 1'b0;
        checkOutput("load3_ready", ld_ready, 1);
        ld_valid = 1'b1;
        ld_data = 8'h81; applyStimulus(1);
        ld_data = 8'h92; applyStimulus(1);
        ld_data = 8'h30; ld_last = 1'b1; applyStimulus(1);
        ld_valid = 1'b0; ld_last = 1'b0;
        checkOutput("load3_ready_drop", ld_ready, 0);
        checkOutput("load3_cpu_still_held", cpu_reset_n, 0);
        checkOutput("load3_count", ld_count, 3);
        applyStimulus(1);
        checkOutput("load3_cpu_released", cpu_reset_n, 1);
        checkRam("load3_ram0", 4'h0, 8'h81);
        checkRam("load3_ram1", 4'h1, 8'h92);
        checkRam("load3_ram2", 4'h2, 8'h30);
        @(negedge clk);

        // CPU write in RUN.
        mem_address = 4'hC; mem_data_w = 8'h05; mem_we = 1'b1; applyStimulus(1); mem_we = 1'b0;
        checkRam("cpuwr_ramC", 4'hC, 8'h05);
        checkOutput("cpuwr_count", wr_count, 1);
        @(negedge clk);

        // 17 bytes without ld_last: only 16 accepted, automatic RUN.
        ld_start = 1'b1; applyStimulus(1); ld_start = 1'b0;
        saw_ready_drop = 1'b0;
        for (int i = 0; i < 17; i++) begin
            ld_valid = 1'b1;
            ld_data  = 8'h40 + 8'(i);
            if (i == 16) begin
                saw_ready_drop = !ld_ready;
            end
            applyStimulus(1);
        end
        ld_valid = 1'b0;
        checkOutput("full_ready_low_at_17th", saw_ready_drop, 1);
        checkOutput("full_count", ld_count, 16);
        checkOutput("full_cpu_released", cpu_reset_n, 1);
        checkOutput("full_wr_count_kept", wr_count, 1);
        checkRam("full_ram0", 4'h0, 8'h40);
        checkRam("full_ramC", 4'hC, 8'h4C);
        checkRam("full_ramF", 4'hF, 8'h4F);
        @(negedge clk);

        // ld_start coincident with a CPU write: write lands, reload from 0.
        mem_address = 4'hA; mem_data_w = 8'hA5; mem_we = 1'b1; ld_start = 1'b1;
        applyStimulus(1);
        mem_we = 1'b0; ld_start = 1'b0;
        checkOutput("reload_cpu_held", cpu_reset_n, 0);
        checkOutput("reload_ready", ld_ready, 1);
        checkOutput("reload_wr_count", wr_count, 2);
        checkOutput("reload_count_cleared", ld_count, 0);
        checkRam("reload_ramA", 4'hA, 8'hA5);
        ld_valid = 1'b1; ld_data = 8'h11; ld_last = 1'b1; applyStimulus(1);
        ld_valid = 1'b0; ld_last = 1'b0;
        checkRam("reload_ram0", 4'h0, 8'h11);
        checkRam("reload_ram1_kept", 4'h1, 8'h41);
        checkOutput("reload_count", ld_count, 1);
        @(negedge clk);

        // Reset in the middle of a load.
        ld_start = 1'b1; applyStimulus(1); ld_start = 1'b0;
        ld_valid = 1'b1;
        ld_data = 8'h66; applyStimulus(1);
        ld_data = 8'h77; applyStimulus(1);
        ld_valid = 1'b0;
        reset = 1'b1; applyStimulus(1); reset = 1'b0;
        checkOutput("midrst_cpu_held", cpu_reset_n, 0);
        checkOutput("midrst_ready", ld_ready, 0);
        checkOutput("midrst_count", ld_count, 0);
        checkOutput("midrst_wr_count", wr_count, 0);
        checkRam("midrst_ram0", 4'h0, 8'h66);
        checkRam("midrst_ram1", 4'h1, 8'h77);
        checkRam("midrst_ram2", 4'h2, 8'h42);
        @(negedge clk);

        // CPU writes are ignored in IDLE.
        mem_address = 4'h5; mem_data_w = 8'hDD; mem_we = 1'b1; applyStimulus(1); mem_we = 1'b0;
        checkRam("idle_wr_ignored", 4'h5, 8'h45);
        checkOutput("idle_wr_count", wr_count, 0);
        @(negedge clk);

        // run_start releases the CPU without loading.
        run_start = 1'b1; applyStimulus(1); run_start = 1'b0;
        checkOutput("run_ready_low", ld_ready, 0);
        applyStimulus(1);
        checkOutput("run_cpu_released", cpu_reset_n, 1);

        // Writes below and above the protect limit.
        mem_address = 4'h3; mem_data_w = 8'hEE; mem_we = 1'b1; applyStimulus(1);
        mem_address = 4'h9; mem_data_w = 8'h99; applyStimulus(1);
        mem_we = 1'b0;
        checkRam("prot_ram9", 4'h9, 8'h99);
`ifdef CPU_MEM_WR_PROTECT_EN
        checkRam("prot_ram3_unchanged", 4'h3, 8'h43);
        checkOutput("prot_err_set", prot_err, 1);
        checkOutput("prot_wr_count", wr_count, 1);
`else
        checkRam("noprot_ram3_written", 4'h3, 8'hEE);
        checkOutput("noprot_err_low", prot_err, 0);
        checkOutput("noprot_wr_count", wr_count, 2);
`endif
        @(negedge clk);

        // ld_start has priority over run_start in IDLE.
        reset = 1'b1; applyStimulus(1); reset = 1'b0;
        ld_start = 1'b1; run_start = 1'b1; applyStimulus(1);
        ld_start = 1'b0; run_start = 1'b0;
        checkOutput("prio_load_wins", ld_ready, 1);
        applyStimulus(1);
        checkOutput("prio_cpu_held", cpu_reset_n, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
